// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch unit: fetch FSM encoding and control-transfer opcodes.
package ifetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DROP  = 3'd3,
    ST_STALL = 3'd4
  } fetch_state_e;

  // True when the instruction can redirect the fetch stream (jal, jalr, conditional branch).
  function automatic logic is_ctrl_xfer(input logic [XLEN-1:0] inst);
    logic [OPC_W-1:0] opc;
    opc = inst[OPC_W-1:0];
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding icache request, holds the word for the decoder, handles redirects.
// Optional macro IFETCH_JUMP_STALL_EN: stall fetch after consuming jal/jalr/branch until a redirect arrives.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst,
  output logic        dec_valid,
  input  logic        need_inst,
  input  logic        clear_inst,
  input  logic [31:0] if_addr,
  input  logic        rob_clear,
  input  logic [31:0] rob_pc
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_dec_pc;
  logic [XLEN-1:0] r_dec_inst;
  logic            r_dec_valid;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_consume;
  logic            w_next_stall;

  // ROB flush outranks the decoder redirect.
  assign w_redirect = rob_clear || clear_inst;
  assign w_target   = rob_clear ? rob_pc : if_addr;
  assign w_consume  = r_dec_valid && !need_inst;

`ifdef IFETCH_JUMP_STALL_EN
  assign w_next_stall = is_ctrl_xfer(r_dec_inst);
`else
  assign w_next_stall = 1'b0;
`endif

  assign icache_req  = (r_state == ST_IDLE) && rdy && !rst && !w_redirect;
  assign icache_addr = r_pc;
  assign dec_pc      = r_dec_pc;
  assign dec_inst    = r_dec_inst;
  assign dec_valid   = r_dec_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_dec_pc    <= '0;
      r_dec_inst  <= '0;
      r_dec_valid <= 1'b0;
    end else if (rdy) begin
      case (r_state)
        ST_IDLE: begin
          if (w_redirect) r_pc    <= w_target;
          else            r_state <= ST_WAIT;
        end
        // A redirect while a response is pending must swallow that response.
        ST_WAIT: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= icache_valid ? ST_IDLE : ST_DROP;
          end else if (icache_valid) begin
            r_dec_inst  <= icache_inst;
            r_dec_pc    <= r_pc;
            r_dec_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_redirect) begin
            r_pc        <= w_target;
            r_dec_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_consume) begin
            r_pc        <= r_pc + PC_STEP;
            r_dec_valid <= 1'b0;
            r_state     <= w_next_stall ? ST_STALL : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_redirect)   r_pc    <= w_target;
          if (icache_valid) r_state <= ST_IDLE;
        end
        ST_STALL: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for the instruction fetch unit.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_valid;
  logic        need_inst;
  logic        clear_inst;
  logic [31:0] if_addr;
  logic        rob_clear;
  logic [31:0] rob_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_inst(icache_inst),
    .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_valid(dec_valid),
    .need_inst(need_inst), .clear_inst(clear_inst), .if_addr(if_addr),
    .rob_clear(rob_clear), .rob_pc(rob_pc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cache model: DUT has just entered WAIT; data arrives in the lat-th WAIT cycle.
  task automatic respond(input int lat, input logic [31:0] inst);
    for (int i = 1; i < lat; i++) tick();
    icache_valid = 1'b1;
    icache_inst  = inst;
    tick();
    icache_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; icache_valid = 1'b0; icache_inst = '0;
    need_inst = 1'b1; clear_inst = 1'b0; if_addr = '0; rob_clear = 1'b0; rob_pc = '0;
    tick(); tick();
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b want=0", icache_req); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rst_dec_valid got=%0b want=0", dec_valid); end
    checks++; if (dec_pc !== 32'h0) begin failures++; $display("FAIL rst_dec_pc got=%h want=0", dec_pc); end
    checks++; if (dec_inst !== 32'h0) begin failures++; $display("FAIL rst_dec_inst got=%h want=0", dec_inst); end
    checks++; if (icache_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", icache_addr); end
    rst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1) begin failures++; $display("FAIL post_rst_req got=%0b want=1", icache_req); end
  endtask

  task automatic test_first_fetch;
    tick();
    checks++; if (icache_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("FAIL wait_state req=%0b dv=%0b want 0/0", icache_req, dec_valid); end
    icache_valid = 1'b1; icache_inst = 32'h0000_0013;
    tick();
    icache_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL first_dec_valid got=%0b want=1", dec_valid); end
    checks++; if (dec_pc !== 32'h0) begin failures++; $display("FAIL first_dec_pc got=%h want=0", dec_pc); end
    checks++; if (dec_inst !== 32'h0000_0013) begin failures++; $display("FAIL first_dec_inst got=%h want=00000013", dec_inst); end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_inst !== 32'h0000_0013 || icache_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d dv=%0b pc=%h inst=%h req=%0b want 1/0/00000013/0", i, dec_valid, dec_pc, dec_inst, icache_req);
      end
    end
    need_inst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL consume_cycle_req got=%0b want=0", icache_req); end
    tick();
    need_inst = 1'b1;
    #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL consume_dv got=%0b want=0", dec_valid); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h4) begin failures++; $display("FAIL consume_next req=%0b addr=%h want 1/00000004", icache_req, icache_addr); end
  endtask

  task automatic test_rdy;
    rdy = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL rdy_low_req got=%0b want=0", icache_req); end
    tick(); tick();
    checks++; if (icache_addr !== 32'h4 || icache_req !== 1'b0) begin failures++; $display("FAIL rdy_low_hold addr=%h req=%0b want 00000004/0", icache_addr, icache_req); end
    rdy = 1'b1;
    #1;
    checks++; if (icache_req !== 1'b1) begin failures++; $display("FAIL rdy_high_req got=%0b want=1", icache_req); end
  endtask

  task automatic test_jal_redirect;
    clear_inst = 1'b1; if_addr = 32'h10;
    #1;
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL idle_redir_req got=%0b want=0", icache_req); end
    tick();
    clear_inst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h10) begin failures++; $display("FAIL idle_redir_addr req=%0b addr=%h want 1/00000010", icache_req, icache_addr); end
    tick();
    respond(1, 32'h0000_006F);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h10) begin failures++; $display("FAIL jal_present dv=%0b pc=%h want 1/00000010", dec_valid, dec_pc); end
    need_inst = 1'b0;
    tick();
    need_inst = 1'b1;
    #1;
`ifdef IFETCH_JUMP_STALL_EN
    checks++; if (icache_req !== 1'b0 || icache_addr !== 32'h14) begin failures++; $display("FAIL jal_stall req=%0b addr=%h want 0/00000014", icache_req, icache_addr); end
    tick();
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL jal_stall2 req=%0b want 0", icache_req); end
    clear_inst = 1'b1; if_addr = 32'h40;
    tick();
    clear_inst = 1'b0;
    #1;
`else
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h14) begin failures++; $display("FAIL jal_spec req=%0b addr=%h want 1/00000014", icache_req, icache_addr); end
    tick();
    clear_inst = 1'b1; if_addr = 32'h40;
    tick();
    clear_inst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("FAIL drop_state req=%0b dv=%0b want 0/0", icache_req, dec_valid); end
    icache_valid = 1'b1; icache_inst = 32'hDEAD_BEEF;
    tick();
    icache_valid = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL stale_0x14 dv=%0b want=0", dec_valid); end
`endif
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h40) begin failures++; $display("FAIL jal_target req=%0b addr=%h want 1/00000040", icache_req, icache_addr); end
    tick();
    respond(2, 32'h0000_0013);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h40 || dec_inst !== 32'h0000_0013) begin failures++; $display("FAIL jal_next dv=%0b pc=%h inst=%h want 1/00000040/00000013", dec_valid, dec_pc, dec_inst); end
  endtask

  task automatic test_priority;
    rob_clear = 1'b1; rob_pc = 32'h100; clear_inst = 1'b1; if_addr = 32'h200; need_inst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL prio_req got=%0b want=0", icache_req); end
    tick();
    rob_clear = 1'b0; clear_inst = 1'b0; need_inst = 1'b1;
    #1;
    checks++; if (dec_valid !== 1'b0 || icache_addr !== 32'h100 || icache_req !== 1'b1) begin failures++; $display("FAIL prio_target dv=%0b addr=%h req=%0b want 0/00000100/1", dec_valid, icache_addr, icache_req); end
    tick();
    respond(1, 32'h0010_0093);
    checks++; if (dec_pc !== 32'h100 || dec_inst !== 32'h0010_0093) begin failures++; $display("FAIL prio_dec pc=%h inst=%h want 00000100/00100093", dec_pc, dec_inst); end
  endtask

  task automatic test_wait_redirect;
    need_inst = 1'b0;
    tick();
    need_inst = 1'b1;
    tick();
    clear_inst = 1'b1; if_addr = 32'h300;
    tick();
    clear_inst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("FAIL wredir_drop req=%0b dv=%0b want 0/0", icache_req, dec_valid); end
    tick();
    clear_inst = 1'b1; if_addr = 32'h380;
    tick();
    clear_inst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0 || icache_addr !== 32'h380) begin failures++; $display("FAIL drop_redir req=%0b addr=%h want 0/00000380", icache_req, icache_addr); end
    icache_valid = 1'b1; icache_inst = 32'h0BAD_0BAD;
    tick();
    icache_valid = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL drop_discard dv=%0b want=0", dec_valid); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h380) begin failures++; $display("FAIL drop_exit req=%0b addr=%h want 1/00000380", icache_req, icache_addr); end
    tick();
    clear_inst = 1'b1; if_addr = 32'h400; icache_valid = 1'b1; icache_inst = 32'h0BAD_0BAD;
    tick();
    clear_inst = 1'b0; icache_valid = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0 || icache_req !== 1'b1 || icache_addr !== 32'h400) begin failures++; $display("FAIL wredir_same dv=%0b req=%0b addr=%h want 0/1/00000400", dec_valid, icache_req, icache_addr); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      exp_pc   = 32'h400 + 32'(4 * k);
      exp_inst = 32'h0000_0013 | (32'(k) << 20);
      tick();
      respond(1, exp_inst);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_inst !== exp_inst) begin failures++; $display("FAIL b2b_%0d dv=%0b pc=%h inst=%h want 1/%h/%h", k, dec_valid, dec_pc, dec_inst, exp_pc, exp_inst); end
      need_inst = 1'b0;
      tick();
      need_inst = 1'b1;
      #1;
      checks++; if (icache_req !== 1'b1 || icache_addr !== exp_pc + 32'h4) begin failures++; $display("FAIL b2b_next_%0d req=%0b addr=%h want 1/%h", k, icache_req, icache_addr, exp_pc + 32'h4); end
    end
  endtask

  task automatic test_wrap;
    clear_inst = 1'b1; if_addr = 32'hFFFF_FFFC;
    tick();
    clear_inst = 1'b0;
    tick();
    respond(1, 32'h0000_0013);
    checks++; if (dec_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_dec_pc got=%h want=fffffffc", dec_pc); end
    need_inst = 1'b0;
    tick();
    need_inst = 1'b1;
    #1;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr req=%0b addr=%h want 1/00000000", icache_req, icache_addr); end
  endtask

  task automatic test_branch;
    clear_inst = 1'b1; if_addr = 32'h20;
    tick();
    clear_inst = 1'b0;
    tick();
    respond(1, 32'h0000_0063);
    checks++; if (dec_pc !== 32'h20 || dec_valid !== 1'b1) begin failures++; $display("FAIL beq_present pc=%h dv=%0b want 00000020/1", dec_pc, dec_valid); end
    need_inst = 1'b0;
    tick();
    need_inst = 1'b1;
    #1;
`ifdef IFETCH_JUMP_STALL_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL beq_stall_%0d req=%0b want 0", i, icache_req); end
      tick();
    end
    clear_inst = 1'b1; if_addr = 32'h60;
    tick();
    clear_inst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h60) begin failures++; $display("FAIL beq_target req=%0b addr=%h want 1/00000060", icache_req, icache_addr); end
`else
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h24) begin failures++; $display("FAIL beq_spec req=%0b addr=%h want 1/00000024", icache_req, icache_addr); end
`endif
  endtask

  task automatic test_reset_in_wait;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (icache_req !== 1'b0 || dec_valid !== 1'b0 || icache_addr !== 32'h0) begin failures++; $display("FAIL rst_wait req=%0b dv=%0b addr=%h want 0/0/00000000", icache_req, dec_valid, icache_addr); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin failures++; $display("FAIL rst_wait_restart req=%0b addr=%h want 1/00000000", icache_req, icache_addr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold();
    test_rdy();
    test_jal_redirect();
    test_priority();
    test_wait_redirect();
    test_back_to_back();
    test_wrap();
    test_branch();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
